// File: rtl/digitizer_pkg.sv
// Shared definitions for the digitizer acquisition core: register map,
// status bit positions and the acquisition FSM state encoding.
package digitizer_pkg;

  localparam logic [1:0] REG_CTRL  = 2'd0;
  localparam logic [1:0] REG_STAT  = 2'd1;
  localparam logic [1:0] REG_SIZE  = 2'd2;
  localparam logic [1:0] REG_COUNT = 2'd3;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_OVF  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/digitizer_axil_regs.sv
// AXI4-Lite slave and register file: SIZE storage, START pulse and
// write-one-to-clear strobes for the sticky status flags.
module digitizer_axil_regs
  import digitizer_pkg::*;
#(
  parameter logic [31:0] SIZE_RST = 32'd0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [3:0]  s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  input  logic        busy,
  input  logic        done,
  input  logic        overflow,
  input  logic [31:0] count,
  output logic [31:0] size,
  output logic        start,
  output logic        clr_done,
  output logic        clr_ovf
);

  logic        wr_en;
  logic        rd_en;
  logic [31:0] rd_mux;
  logic        unused_addr_lsbs;

  // Handshake: a channel transfers on the edge where valid and ready are both high;
  // ready is only raised while the corresponding response slot is free.
  assign s_axi_awready = s_axi_awvalid && s_axi_wvalid && !s_axi_bvalid;
  assign s_axi_wready  = s_axi_awready;
  assign s_axi_arready = s_axi_arvalid && !s_axi_rvalid;
  assign wr_en         = s_axi_awready;
  assign rd_en         = s_axi_arready;
  assign s_axi_bresp   = 2'b00;
  assign s_axi_rresp   = 2'b00;
  assign unused_addr_lsbs = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  assign start    = wr_en && (s_axi_awaddr[3:2] == REG_CTRL) && s_axi_wstrb[0] && s_axi_wdata[0];
  assign clr_done = wr_en && (s_axi_awaddr[3:2] == REG_STAT) && s_axi_wstrb[0] && s_axi_wdata[STAT_DONE];
  assign clr_ovf  = wr_en && (s_axi_awaddr[3:2] == REG_STAT) && s_axi_wstrb[0] && s_axi_wdata[STAT_OVF];

  always_comb begin
    rd_mux = '0;
    case (s_axi_araddr[3:2])
      REG_STAT: begin
        rd_mux[STAT_BUSY] = busy;
        rd_mux[STAT_DONE] = done;
        rd_mux[STAT_OVF]  = overflow;
      end
      REG_SIZE:  rd_mux = size;
      REG_COUNT: rd_mux = count;
      default:   rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s_axi_bvalid <= 1'b0;
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= '0;
      size         <= {SIZE_RST[31:2], 2'b00};
    end else begin
      if (s_axi_bvalid && s_axi_bready) s_axi_bvalid <= 1'b0;
      else if (wr_en)                   s_axi_bvalid <= 1'b1;

      if (rd_en) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rdata  <= rd_mux;
      end else if (s_axi_rready) begin
        s_axi_rvalid <= 1'b0;
      end

      // Packets are whole 32-bit beats, so the byte count is kept word aligned.
      if (wr_en && (s_axi_awaddr[3:2] == REG_SIZE)) begin
        for (int b = 0; b < 4; b++) begin
          if (s_axi_wstrb[b]) size[8*b +: 8] <= s_axi_wdata[8*b +: 8];
        end
        size[1:0] <= 2'b00;
      end
    end
  end

endmodule

// File: rtl/digitizer_core.sv
// Digitizer acquisition core: packs pairs of ADC samples into 32-bit words
// and streams one fixed-size packet per START over AXI4-Stream.
module digitizer_core
  import digitizer_pkg::*;
#(
  parameter int          ADC_W    = 16,
  parameter logic [31:0] SIZE_RST = 32'd0
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [ADC_W-1:0]       adc_data,
  input  logic [3:0]             s_axi_awaddr,
  input  logic                   s_axi_awvalid,
  output logic                   s_axi_awready,
  input  logic [31:0]            s_axi_wdata,
  input  logic [3:0]             s_axi_wstrb,
  input  logic                   s_axi_wvalid,
  output logic                   s_axi_wready,
  output logic [1:0]             s_axi_bresp,
  output logic                   s_axi_bvalid,
  input  logic                   s_axi_bready,
  input  logic [3:0]             s_axi_araddr,
  input  logic                   s_axi_arvalid,
  output logic                   s_axi_arready,
  output logic [31:0]            s_axi_rdata,
  output logic [1:0]             s_axi_rresp,
  output logic                   s_axi_rvalid,
  input  logic                   s_axi_rready,
  output logic [2*ADC_W-1:0]     m_axis_tdata,
  output logic [2*ADC_W/8-1:0]   m_axis_tkeep,
  output logic                   m_axis_tvalid,
  output logic                   m_axis_tlast,
  input  logic                   m_axis_tready,
  output logic                   led,
  output state_t                 dbg_state
);

  state_t            state_q, state_d;
  logic              phase_q;
  logic [ADC_W-1:0]  low_q;
  logic [31:0]       beats_q, loaded_q, count_q;
  logic              done_q, ovf_q;
  logic [31:0]       size;
  logic              start, clr_done, clr_ovf;
  logic              go, finish, accept;

  digitizer_axil_regs #(.SIZE_RST(SIZE_RST)) u_regs (
    .clk           (clk),
    .resetn        (resetn),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .busy          (led),
    .done          (done_q),
    .overflow      (ovf_q),
    .count         (count_q),
    .size          (size),
    .start         (start),
    .clr_done      (clr_done),
    .clr_ovf       (clr_ovf)
  );

  assign accept       = m_axis_tvalid && m_axis_tready;
  assign m_axis_tkeep = '1;
  assign led          = (state_q == RUN);
  assign dbg_state    = state_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    go      = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: if (start && (size[31:2] != '0)) begin
        state_d = RUN;
        go      = 1'b1;
      end
      RUN: if (accept && m_axis_tlast) begin
        state_d = IDLE;
        finish  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      phase_q       <= 1'b0;
      low_q         <= '0;
      beats_q       <= '0;
      loaded_q      <= '0;
      count_q       <= '0;
      done_q        <= 1'b0;
      ovf_q         <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else begin
      if (clr_done) done_q <= 1'b0;
      if (clr_ovf)  ovf_q  <= 1'b0;
      if (go) begin
        phase_q  <= 1'b0;
        beats_q  <= size >> 2;
        loaded_q <= '0;
        count_q  <= '0;
        done_q   <= 1'b0;
        ovf_q    <= 1'b0;
      end else if (state_q == RUN) begin
        phase_q <= !phase_q;
        if (!phase_q) low_q <= adc_data;
        if (accept) count_q <= count_q + 32'd1;
        // Words completed after the last beat was loaded fall outside the packet.
        if (finish) begin
          m_axis_tvalid <= 1'b0;
          m_axis_tlast  <= 1'b0;
          done_q        <= 1'b1;
        end else if (phase_q && (loaded_q != beats_q)) begin
          if (!m_axis_tvalid || m_axis_tready) begin
            m_axis_tdata  <= {adc_data, low_q};
            m_axis_tlast  <= (loaded_q == beats_q - 32'd1);
            m_axis_tvalid <= 1'b1;
            loaded_q      <= loaded_q + 32'd1;
          end else begin
            ovf_q <= 1'b1;
          end
        end else if (accept) begin
          m_axis_tvalid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_digitizer_core.sv
// Bench for digitizer_core: register access, packet streaming and abort cases.
module tb_digitizer_core;
  import digitizer_pkg::*;

  localparam logic [31:0] SIZE_RST = 32'h0000_0040;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [15:0] adc_data = '0;
  logic [3:0]  s_axi_awaddr = '0;
  logic        s_axi_awvalid = 1'b0;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0]  s_axi_wstrb = '0;
  logic        s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 1'b0;
  logic [3:0]  s_axi_araddr = '0;
  logic        s_axi_arvalid = 1'b0;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready = 1'b0;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready = 1'b0;
  logic        led;
  state_t      dbg_state;

  int          checks = 0;
  int          errors = 0;
  logic [32:0] exp_q[$];
  int          mode = 0;
  int          exp_beats = 0;
  int          beat_idx = 0;
  int          prev_low = -1;
  bit          hold_pending = 0;
  logic [32:0] held = '0;
  bit          ramp_rst = 0;
  bit          ready_rand = 0;
  logic        ready_level = 1'b0;
  logic [31:0] rd;

  digitizer_core #(.ADC_W(16), .SIZE_RST(SIZE_RST)) dut (
    .clk(clk), .resetn(resetn), .adc_data(adc_data),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready), .led(led), .dbg_state(dbg_state)
  );

  // Clock and free-running stimulus sources
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk); #1;
    if (ramp_rst) begin
      adc_data = '0;
      ramp_rst = 0;
    end else begin
      adc_data = adc_data + 16'd1;
    end
  end

  initial forever begin
    @(posedge clk); #1;
    m_axis_tready = ready_rand ? 1'($urandom_range(0, 1)) : ready_level;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input bit restart);
    int n;
    @(negedge clk);
    s_axi_awaddr = addr; s_axi_awvalid = 1'b1;
    s_axi_wdata = data; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    #1;
    n = 0;
    while (!s_axi_awready && n < 20) begin @(negedge clk); #1; n++; end
    check("awready", s_axi_awready, 1);
    if (restart) ramp_rst = 1;
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b1;
    check("bvalid", s_axi_bvalid, 1);
    check("bresp", s_axi_bresp, 2'b00);
    @(posedge clk); #1;
    s_axi_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
    int n;
    @(negedge clk);
    s_axi_araddr = addr; s_axi_arvalid = 1'b1;
    #1;
    n = 0;
    while (!s_axi_arready && n < 20) begin @(negedge clk); #1; n++; end
    check("arready", s_axi_arready, 1);
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
    check("rvalid", s_axi_rvalid, 1);
    check("rresp", s_axi_rresp, 2'b00);
    data = s_axi_rdata;
    @(posedge clk); #1;
    s_axi_rready = 1'b0;
  endtask

  task automatic check_reg(input string name, input logic [3:0] addr, input logic [31:0] exp);
    logic [31:0] v;
    axi_read(addr, v);
    check(name, v, exp);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (led && n < budget) begin @(negedge clk); n++; end
    check("idle_timeout", led, 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic push_ramp(input int n);
    for (int k = 0; k < n; k++)
      exp_q.push_back({(k == n - 1), 16'(2 * k + 1), 16'(2 * k)});
  endtask

  // Scoreboard monitor: samples mid-cycle, a handshake lands on the next posedge
  always @(negedge clk) begin
    if (!resetn || mode == 2) begin
      hold_pending = 0;
    end else begin
      if (hold_pending) check("stall_hold", {m_axis_tlast, m_axis_tdata}, held);
      if (m_axis_tvalid && m_axis_tready) begin
        check("tkeep", m_axis_tkeep, 4'hF);
        if (mode == 0) begin
          if (exp_q.size() == 0) check("unexpected_beat", {m_axis_tlast, m_axis_tdata}, 33'h0);
          else check("beat", {m_axis_tlast, m_axis_tdata}, exp_q.pop_front());
        end else begin
          check("beat_pair", m_axis_tdata[31:16], m_axis_tdata[15:0] + 16'd1);
          check("beat_even", m_axis_tdata[0], 0);
          check("beat_order", int'(m_axis_tdata[15:0]) > prev_low, 1);
          check("beat_tlast", m_axis_tlast, beat_idx == exp_beats - 1);
          prev_low = int'(m_axis_tdata[15:0]);
        end
        beat_idx++;
        hold_pending = 0;
      end else if (m_axis_tvalid) begin
        hold_pending = 1;
        held = {m_axis_tlast, m_axis_tdata};
      end else begin
        hold_pending = 0;
      end
    end
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_led", led, 0);
    check("rst_state", dbg_state, IDLE);
    check("rst_axi", {s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid}, 0);
    resetn = 1'b1;
    check_reg("rst_stat", 4'h4, 32'h0);
    check_reg("rst_size", 4'h8, SIZE_RST);
    check_reg("rst_count", 4'hC, 32'h0);
    check_reg("ctrl_reads0", 4'h0, 32'h0);

    // Full ramp packet with an always-ready sink
    ready_level = 1'b1;
    axi_write(4'h8, 32'd65536, 0);
    check_reg("size_rb", 4'h8, 32'd65536);
    mode = 0; beat_idx = 0;
    push_ramp(16384);
    axi_write(4'h0, 32'h1, 1);
    check("busy_led", led, 1);
    wait_idle(40000);
    check("ramp_beats", beat_idx, 16384);
    check("ramp_q_empty", exp_q.size(), 0);
    check_reg("ramp_stat", 4'h4, 32'h2);
    check_reg("ramp_count", 4'hC, 32'd16384);
    axi_write(4'h4, 32'h2, 0);
    check_reg("w1c_done", 4'h4, 32'h0);

    // Randomly stalling sink: drops set OVERFLOW, accepted beats stay well formed
    axi_write(4'h8, 32'd8192, 0);
    mode = 1; beat_idx = 0; exp_beats = 2048; prev_low = -1;
    ready_rand = 1;
    axi_write(4'h0, 32'h1, 1);
    wait_idle(30000);
    ready_rand = 0;
    check("rand_beats", beat_idx, 2048);
    check_reg("rand_stat", 4'h4, 32'h6);
    check_reg("rand_count", 4'hC, 32'd2048);
    axi_write(4'h4, 32'h6, 0);
    check_reg("w1c_both", 4'h4, 32'h0);

    // Single-beat packet
    repeat (2) @(negedge clk);
    axi_write(4'h8, 32'd4, 0);
    mode = 0; beat_idx = 0;
    push_ramp(1);
    axi_write(4'h0, 32'h1, 1);
    wait_idle(100);
    check("one_beats", beat_idx, 1);
    check_reg("one_stat", 4'h4, 32'h2);
    axi_write(4'h4, 32'h2, 0);

    // Undersized packets are ignored; SIZE low bits read as zero
    axi_write(4'h8, 32'd7, 0);
    check_reg("size_align", 4'h8, 32'd4);
    axi_write(4'h8, 32'd2, 0);
    check_reg("size_two", 4'h8, 32'd0);
    beat_idx = 0;
    axi_write(4'h0, 32'h1, 0);
    repeat (5) @(negedge clk);
    check("size2_led", led, 0);
    axi_write(4'h8, 32'd0, 0);
    axi_write(4'h0, 32'h1, 0);
    repeat (5) @(negedge clk);
    check("size0_led", led, 0);
    check("small_beats", beat_idx, 0);
    check_reg("small_stat", 4'h4, 32'h0);

    // START and W1C while running leave the packet intact
    axi_write(4'h8, 32'd256, 0);
    mode = 0; beat_idx = 0;
    push_ramp(64);
    axi_write(4'h0, 32'h1, 1);
    axi_write(4'h0, 32'h1, 0);
    axi_write(4'h4, 32'h2, 0);
    check("run_led", led, 1);
    wait_idle(500);
    check("run_beats", beat_idx, 64);
    check("run_q_empty", exp_q.size(), 0);
    check_reg("run_stat", 4'h4, 32'h2);
    check_reg("run_count", 4'hC, 32'd64);

    // Asynchronous reset in the middle of a stalled packet
    mode = 2;
    ready_level = 1'b0;
    axi_write(4'h0, 32'h1, 1);
    repeat (10) @(negedge clk);
    check("pre_abort_tvalid", m_axis_tvalid, 1);
    @(posedge clk); #3;
    resetn = 1'b0;
    #1;
    check("abort_tvalid", m_axis_tvalid, 0);
    check("abort_tlast", m_axis_tlast, 0);
    check("abort_led", led, 0);
    @(negedge clk);
    resetn = 1'b1;
    check_reg("abort_stat", 4'h4, 32'h0);
    check_reg("abort_count", 4'hC, 32'h0);
    check_reg("abort_size", 4'h8, SIZE_RST);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
